// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants for the writeback arbiter
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_IMM  = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester bundle (valid/ready, packed dest/data, hold)
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
);

  logic                      wb_hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output wb_hold, req_valid, req_dest, req_data,
    input  req_ready
  );

  modport slave (
    input  wb_hold, req_valid, req_dest, req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin one-hot grant with hold and pointer state
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;

  // Scan from r_ptr upward, wrapping; no grant at all while held or in reset.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(r_ptr) + k >= NUM_REQ) begin
        w_cand = IDX_W'(int'(r_ptr) + k - NUM_REQ);
      end else begin
        w_cand = IDX_W'(int'(r_ptr) + k);
      end
      if (!w_found && req[w_cand] && !hold && rst_n) begin
        w_found        = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_grant_idx    = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_grant_idx;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter onto the 8x16 regfile write port, r0 writes dropped
// Optional bypass compare ports built when WB_ARB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 reg_write_en,
  output logic [ADDR_W-1:0]    reg_write_dest,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic                 dropped_r0
`ifdef WB_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    byp_addr1,
  input  logic [ADDR_W-1:0]    byp_addr2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [DATA_W-1:0]    byp_data1,
  output logic [DATA_W-1:0]    byp_data2
`endif
);

  import regfile_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_dest;
  logic [DATA_W-1:0]  w_data;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_dest;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_dropped;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wb.req_valid),
    .hold      (wb.wb_hold),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign wb.req_ready = w_grant;
  assign w_accept     = |w_grant;
  assign w_dest       = wb.req_dest[int'(w_grant_idx)*ADDR_W +: ADDR_W];
  assign w_data       = wb.req_data[int'(w_grant_idx)*DATA_W +: DATA_W];

  // An r0 write is consumed (ready given) but never reaches the regfile; dest/data keep last write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_dest <= '0;
      r_wr_data <= '0;
      r_dropped <= 1'b0;
    end else if (w_accept && (w_dest != ADDR_W'(REG_ZERO))) begin
      r_wr_en   <= 1'b1;
      r_wr_dest <= w_dest;
      r_wr_data <= w_data;
      r_dropped <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_dropped <= w_accept;
    end
  end

  assign reg_write_en   = r_wr_en;
  assign reg_write_dest = r_wr_dest;
  assign reg_write_data = r_wr_data;
  assign dropped_r0     = r_dropped;

`ifdef WB_ARB_BYPASS_EN
  assign byp_hit1  = r_wr_en && (r_wr_dest == byp_addr1) && (byp_addr1 != ADDR_W'(REG_ZERO));
  assign byp_hit2  = r_wr_en && (r_wr_dest == byp_addr2) && (byp_addr2 != ADDR_W'(REG_ZERO));
  assign byp_data1 = byp_hit1 ? r_wr_data : '0;
  assign byp_data2 = byp_hit2 ? r_wr_data : '0;
`endif

endmodule
